// File: rtl/slot_sequencer.sv
// Slot-table sequencer: sweeps slots in ascending order, issues one MM2S/S2MM
// command pair per READY slot, then writes back status and a cycle-count profile.
module slot_sequencer #(
    parameter int INDEX_WIDTH   = 3,
    parameter int ADDR_WIDTH    = 32,
    parameter int SIZE_WIDTH    = 26,
    parameter int STATUS_WIDTH  = 2,
    parameter int PROFILE_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     err_flag,
    output logic [INDEX_WIDTH-1:0]   cur_slot,
    output logic [INDEX_WIDTH-1:0]   tbl_out_index,
    input  logic [ADDR_WIDTH-1:0]    tbl_src_addr,
    input  logic [SIZE_WIDTH-1:0]    tbl_src_size,
    input  logic [ADDR_WIDTH-1:0]    tbl_des_addr,
    input  logic [SIZE_WIDTH-1:0]    tbl_des_size,
    input  logic [STATUS_WIDTH-1:0]  tbl_status,
    output logic [INDEX_WIDTH-1:0]   tbl_inp_index,
    output logic [STATUS_WIDTH-1:0]  tbl_inp_status,
    output logic [PROFILE_WIDTH-1:0] tbl_inp_profile,
    output logic                     tbl_set_status,
    output logic                     tbl_set_profile,
    output logic                     mm2s_valid,
    input  logic                     mm2s_ready,
    output logic [ADDR_WIDTH-1:0]    mm2s_addr,
    output logic [SIZE_WIDTH-1:0]    mm2s_len,
    input  logic                     mm2s_done,
    output logic                     s2mm_valid,
    input  logic                     s2mm_ready,
    output logic [ADDR_WIDTH-1:0]    s2mm_addr,
    output logic [SIZE_WIDTH-1:0]    s2mm_len,
    input  logic                     s2mm_done,
    input  logic                     dma_err
);
    localparam logic [STATUS_WIDTH-1:0] ST_READY = STATUS_WIDTH'(1);
    localparam logic [STATUS_WIDTH-1:0] ST_DONE  = STATUS_WIDTH'(2);
    localparam logic [STATUS_WIDTH-1:0] ST_ERROR = STATUS_WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRBACK, S_NEXT
    } state_e;

    state_e                   state_q;
    logic [INDEX_WIDTH-1:0]   cur_slot_q;
    logic                     sweep_done_q, err_flag_q;
    logic                     mm2s_valid_q, s2mm_valid_q;
    logic [ADDR_WIDTH-1:0]    mm2s_addr_q, s2mm_addr_q;
    logic [SIZE_WIDTH-1:0]    mm2s_len_q, s2mm_len_q;
    logic                     mm2s_acc_q, s2mm_acc_q, mm2s_fin_q, s2mm_fin_q;
    logic [PROFILE_WIDTH-1:0] prof_q;
    logic                     set_q;
    logic [STATUS_WIDTH-1:0]  inp_status_q;
    logic [PROFILE_WIDTH-1:0] inp_profile_q;

    logic                     mm2s_acc_d, s2mm_acc_d, mm2s_fin_d, s2mm_fin_d;
    logic [PROFILE_WIDTH-1:0] prof_d;

    // Handshakes and done pulses seen this cycle count immediately.
    always_comb begin
        mm2s_acc_d = mm2s_acc_q | (mm2s_valid_q & mm2s_ready);
        s2mm_acc_d = s2mm_acc_q | (s2mm_valid_q & s2mm_ready);
        mm2s_fin_d = mm2s_fin_q | mm2s_done;
        s2mm_fin_d = s2mm_fin_q | s2mm_done;
        prof_d     = (&prof_q) ? prof_q : prof_q + PROFILE_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cur_slot_q    <= '0;
            sweep_done_q  <= 1'b0;
            err_flag_q    <= 1'b0;
            mm2s_valid_q  <= 1'b0;
            s2mm_valid_q  <= 1'b0;
            mm2s_addr_q   <= '0;
            s2mm_addr_q   <= '0;
            mm2s_len_q    <= '0;
            s2mm_len_q    <= '0;
            mm2s_acc_q    <= 1'b0;
            s2mm_acc_q    <= 1'b0;
            mm2s_fin_q    <= 1'b0;
            s2mm_fin_q    <= 1'b0;
            prof_q        <= '0;
            set_q         <= 1'b0;
            inp_status_q  <= '0;
            inp_profile_q <= '0;
        end else begin
            // NOTE: pulse outputs default low here with <=; a later <= in the case wins.
            sweep_done_q  <= 1'b0;
            set_q         <= 1'b0;
            inp_status_q  <= '0;
            inp_profile_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_slot_q <= '0;
                        err_flag_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (tbl_status != ST_READY) begin
                        state_q <= S_NEXT;
                    end else begin
                        mm2s_addr_q  <= tbl_src_addr;
                        mm2s_len_q   <= tbl_src_size;
                        s2mm_addr_q  <= tbl_des_addr;
                        s2mm_len_q   <= tbl_des_size;
                        mm2s_valid_q <= (tbl_src_size != '0);
                        s2mm_valid_q <= (tbl_des_size != '0);
                        mm2s_acc_q   <= (tbl_src_size == '0);
                        s2mm_acc_q   <= (tbl_des_size == '0);
                        mm2s_fin_q   <= (tbl_src_size == '0);
                        s2mm_fin_q   <= (tbl_des_size == '0);
                        prof_q       <= '0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    prof_q     <= prof_d;
                    mm2s_acc_q <= mm2s_acc_d;
                    s2mm_acc_q <= s2mm_acc_d;
                    mm2s_fin_q <= mm2s_fin_d;
                    s2mm_fin_q <= s2mm_fin_d;
                    if (dma_err) begin
                        mm2s_valid_q  <= 1'b0;
                        s2mm_valid_q  <= 1'b0;
                        err_flag_q    <= 1'b1;
                        set_q         <= 1'b1;
                        inp_status_q  <= ST_ERROR;
                        inp_profile_q <= prof_d;
                        state_q       <= S_WRBACK;
                    end else if (state_q == S_ISSUE) begin
                        if (mm2s_valid_q && mm2s_ready) mm2s_valid_q <= 1'b0;
                        if (s2mm_valid_q && s2mm_ready) s2mm_valid_q <= 1'b0;
                        if (mm2s_acc_d && s2mm_acc_d) state_q <= S_WAIT;
                    end else if (mm2s_fin_d && s2mm_fin_d) begin
                        set_q         <= 1'b1;
                        inp_status_q  <= ST_DONE;
                        inp_profile_q <= prof_d;
                        state_q       <= S_WRBACK;
                    end
                end
                S_WRBACK: state_q <= S_NEXT;
                S_NEXT: begin
                    if ((&cur_slot_q) || stop || err_flag_q) begin
                        sweep_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cur_slot_q <= cur_slot_q + INDEX_WIDTH'(1);
                        state_q    <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign sweep_done      = sweep_done_q;
    assign err_flag        = err_flag_q;
    assign cur_slot        = cur_slot_q;
    assign tbl_out_index   = cur_slot_q;
    assign tbl_inp_index   = cur_slot_q;
    assign tbl_inp_status  = inp_status_q;
    assign tbl_inp_profile = inp_profile_q;
    assign tbl_set_status  = set_q;
    assign tbl_set_profile = set_q;
    assign mm2s_valid      = mm2s_valid_q;
    assign mm2s_addr       = mm2s_addr_q;
    assign mm2s_len        = mm2s_len_q;
    assign s2mm_valid      = s2mm_valid_q;
    assign s2mm_addr       = s2mm_addr_q;
    assign s2mm_len        = s2mm_len_q;

endmodule

// File: tb/tb_slot_sequencer.sv
// Bench for slot_sequencer: table model, scripted DMA responder, vector table,
// corner-case sequences and randomized sweeps against a timing/outcome model.
module tb_slot_sequencer;
    localparam int IW = 3, AW = 32, SW = 26, STW = 2, PW = 32;
    localparam int NS = 1 << IW;

    typedef struct { int r; int d; } resp_t;
    typedef struct {
        logic [SW-1:0] ssz;
        logic [SW-1:0] dsz;
        resp_t         m;
        resp_t         s;
        int            prof;
        int            hm;
        int            hs;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start, stop, dma_err;
    logic busy, sweep_done, err_flag;
    logic [IW-1:0] cur_slot, tbl_out_index, tbl_inp_index;
    logic [AW-1:0] tbl_src_addr, tbl_des_addr, mm2s_addr, s2mm_addr;
    logic [SW-1:0] tbl_src_size, tbl_des_size, mm2s_len, s2mm_len;
    logic [STW-1:0] tbl_status, tbl_inp_status;
    logic [PW-1:0] tbl_inp_profile;
    logic tbl_set_status, tbl_set_profile;
    logic mm2s_valid, mm2s_ready, mm2s_done, s2mm_valid, s2mm_ready, s2mm_done;

    // Slot table and DMA responder state
    logic [AW-1:0]  t_src [NS];
    logic [AW-1:0]  t_des [NS];
    logic [SW-1:0]  t_ssz [NS];
    logic [SW-1:0]  t_dsz [NS];
    logic [STW-1:0] t_st  [NS];
    logic [PW-1:0]  t_prof[NS];
    logic rdy [2];
    logic dn  [2];
    bit   act [2];
    int   rdel[2], dcnt[2], dd[2];
    resp_t         rq  [2][$];
    logic [AW-1:0] hs_a[2][$];
    logic [SW-1:0] hs_l[2][$];
    int n_wr, n_chk, n_bad;
    vec_t vecs[6];

    always #5 clk = ~clk;

    assign tbl_src_addr = t_src[tbl_out_index];
    assign tbl_des_addr = t_des[tbl_out_index];
    assign tbl_src_size = t_ssz[tbl_out_index];
    assign tbl_des_size = t_dsz[tbl_out_index];
    assign tbl_status   = t_st[tbl_out_index];
    assign mm2s_ready = rdy[0];
    assign mm2s_done  = dn[0];
    assign s2mm_ready = rdy[1];
    assign s2mm_done  = dn[1];

    logic any_out;
    assign any_out = |{busy, sweep_done, err_flag, cur_slot, tbl_out_index, tbl_inp_index,
                       tbl_inp_status, tbl_inp_profile, tbl_set_status, tbl_set_profile,
                       mm2s_valid, mm2s_addr, mm2s_len, s2mm_valid, s2mm_addr, s2mm_len};

    slot_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .busy(busy),
        .sweep_done(sweep_done), .err_flag(err_flag), .cur_slot(cur_slot),
        .tbl_out_index(tbl_out_index), .tbl_src_addr(tbl_src_addr),
        .tbl_src_size(tbl_src_size), .tbl_des_addr(tbl_des_addr),
        .tbl_des_size(tbl_des_size), .tbl_status(tbl_status),
        .tbl_inp_index(tbl_inp_index), .tbl_inp_status(tbl_inp_status),
        .tbl_inp_profile(tbl_inp_profile), .tbl_set_status(tbl_set_status),
        .tbl_set_profile(tbl_set_profile), .mm2s_valid(mm2s_valid),
        .mm2s_ready(mm2s_ready), .mm2s_addr(mm2s_addr), .mm2s_len(mm2s_len),
        .mm2s_done(mm2s_done), .s2mm_valid(s2mm_valid), .s2mm_ready(s2mm_ready),
        .s2mm_addr(s2mm_addr), .s2mm_len(s2mm_len), .s2mm_done(s2mm_done),
        .dma_err(dma_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic ch_valid(input int c);
        return (c == 0) ? mm2s_valid : s2mm_valid;
    endfunction

    // One cycle: wait for the falling edge, apply table writes, drive the responder.
    task automatic tick();
        resp_t cur;
        @(negedge clk);
        dma_err = 1'b0;
        if (tbl_set_status) begin
            t_st[tbl_inp_index] = tbl_inp_status;
            n_wr++;
        end
        if (tbl_set_profile) t_prof[tbl_inp_index] = tbl_inp_profile;
        for (int c = 0; c < 2; c++) begin
            dn[c]  = 1'b0;
            rdy[c] = 1'b0;
            if (dcnt[c] > 0) begin
                dcnt[c]--;
                if (dcnt[c] == 0) dn[c] = 1'b1;
            end
            if (ch_valid(c) && !act[c] && rq[c].size() > 0) begin
                cur     = rq[c].pop_front();
                act[c]  = 1'b1;
                rdel[c] = cur.r;
                dd[c]   = cur.d;
            end
            if (act[c] && ch_valid(c)) begin
                if (rdel[c] == 0) begin
                    rdy[c] = 1'b1;
                    act[c] = 1'b0;
                    if (dd[c] == 0) dn[c] = 1'b1;
                    else dcnt[c] = dd[c];
                    hs_a[c].push_back((c == 0) ? mm2s_addr : s2mm_addr);
                    hs_l[c].push_back((c == 0) ? mm2s_len : s2mm_len);
                end else begin
                    rdel[c]--;
                end
            end
        end
    endtask

    task automatic reset_resp();
        for (int c = 0; c < 2; c++) begin
            rq[c].delete();
            hs_a[c].delete();
            hs_l[c].delete();
            act[c] = 1'b0; rdel[c] = 0; dcnt[c] = 0; dd[c] = 0;
            rdy[c] = 1'b0; dn[c] = 1'b0;
        end
        n_wr = 0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NS; i++) begin
            t_src[i] = 32'hA000_0000 + 32'(i); t_des[i] = 32'hB000_0000 + 32'(i);
            t_ssz[i] = '0; t_dsz[i] = '0; t_st[i] = 2'd0;
            t_prof[i] = 32'hCAFE_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; dma_err = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic start_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // n counts cycles from the start cycle to the cycle showing sweep_done.
    task automatic wait_sweep(input int budget, output int n);
        n = 1;
        while (!sweep_done && n < budget) begin
            tick();
            n++;
        end
        if (!sweep_done) begin
            n_chk++; n_bad++;
            $display("FAIL sweep_timeout: no sweep_done within %0d cycles", budget);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!(mm2s_valid || s2mm_valid) && n < budget) begin
            tick();
            n++;
        end
        if (!(mm2s_valid || s2mm_valid)) begin
            n_chk++; n_bad++;
            $display("FAIL valid_timeout: no command valid within %0d cycles", budget);
        end
    endtask

    // Profile from the rules: ISSUE ends when both are accepted, WAIT lasts at
    // least one cycle, completion is the later of that and the last done pulse.
    function automatic int model_profile(input logic [SW-1:0] ssz, input logic [SW-1:0] dsz,
                                         input resp_t m, input resp_t s);
        int a = 0, c;
        if (ssz != 0 && m.r > a) a = m.r;
        if (dsz != 0 && s.r > a) a = s.r;
        c = a + 1;
        if (ssz != 0 && m.r + m.d > c) c = m.r + m.d;
        if (dsz != 0 && s.r + s.d > c) c = s.r + s.d;
        return c + 1;
    endfunction

    function automatic vec_t mk_vec(input int ssz, input int dsz, input int mr, input int md,
                                    input int sr, input int sd, input int prof, input int hm,
                                    input int hs);
        vec_t v;
        v.ssz = SW'(ssz); v.dsz = SW'(dsz);
        v.m.r = mr; v.m.d = md; v.s.r = sr; v.s.d = sd;
        v.prof = prof; v.hm = hm; v.hs = hs;
        return v;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec_t v;
        n_chk = 0; n_bad = 0;
        reset_resp();
        clear_table();
        do_reset();

        // Reset state
        check("reset_outputs_zero", 64'(any_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Single-slot vectors on slot 0: {src_len, dst_len, m{r,d}, s{r,d}, profile, hs_m, hs_s}
        vecs[0] = mk_vec(64, 64, 0, 5, 0, 5, 6, 1, 1);
        vecs[1] = mk_vec(0, 16, 0, 0, 0, 2, 3, 0, 1);
        vecs[2] = mk_vec(32, 32, 4, 0, 0, 1, 6, 1, 1);
        vecs[3] = mk_vec(0, 0, 0, 0, 0, 0, 2, 0, 0);
        vecs[4] = mk_vec(8, 0, 1, 7, 0, 0, 9, 1, 0);
        vecs[5] = mk_vec(16, 16, 0, 0, 0, 0, 2, 1, 1);
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            reset_resp();
            clear_table();
            t_st[0] = 2'd1; t_src[0] = 32'h1000; t_des[0] = 32'h2000;
            t_ssz[0] = v.ssz; t_dsz[0] = v.dsz;
            if (v.ssz != 0) rq[0].push_back(v.m);
            if (v.dsz != 0) rq[1].push_back(v.s);
            start_sweep();
            wait_sweep(200, n);
            check($sformatf("v%0d_sweep_cycles", i), 64'(n), 64'(v.prof + 18));
            check($sformatf("v%0d_status", i), 64'(t_st[0]), 64'd2);
            check($sformatf("v%0d_profile", i), 64'(t_prof[0]), 64'(v.prof));
            check($sformatf("v%0d_hs_mm2s", i), 64'(hs_a[0].size()), 64'(v.hm));
            check($sformatf("v%0d_hs_s2mm", i), 64'(hs_a[1].size()), 64'(v.hs));
            if (hs_a[0].size() > 0)
                check($sformatf("v%0d_mm2s_cmd", i), {hs_a[0][0], 6'd0, hs_l[0][0]},
                      {32'h1000, 6'd0, v.ssz});
            if (hs_a[1].size() > 0)
                check($sformatf("v%0d_s2mm_cmd", i), {hs_a[1][0], 6'd0, hs_l[1][0]},
                      {32'h2000, 6'd0, v.dsz});
            check($sformatf("v%0d_writes", i), 64'(n_wr), 64'd1);
            check($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
            tick();
            check($sformatf("v%0d_done_pulse", i), 64'(sweep_done), 64'd0);
        end

        // All slots EMPTY; a second start mid-sweep must be ignored
        reset_resp();
        clear_table();
        start_sweep();
        n = 1;
        while (!sweep_done && n < 100) begin
            start = (n == 5);
            tick();
            n++;
            if (mm2s_valid || s2mm_valid) check("empty_no_valid", 64'd1, 64'd0);
        end
        start = 1'b0;
        check("empty_sweep_cycles", 64'(n), 64'd17);
        check("empty_no_writes", 64'(n_wr), 64'd0);

        // mm2s_ready low for 4 cycles, s2mm accepted at once
        reset_resp();
        clear_table();
        t_st[0] = 2'd1; t_src[0] = 32'h1000; t_des[0] = 32'h2000;
        t_ssz[0] = 26'd64; t_dsz[0] = 26'd64;
        rq[0].push_back('{r: 4, d: 1});
        rq[1].push_back('{r: 0, d: 1});
        start_sweep();
        wait_valid(20);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("stall_mm2s_valid_c%0d", k), 64'(mm2s_valid), 64'(k <= 4));
            check($sformatf("stall_s2mm_valid_c%0d", k), 64'(s2mm_valid), 64'(k == 0));
            if (k <= 4)
                check($sformatf("stall_mm2s_cmd_c%0d", k), {mm2s_addr, 6'd0, mm2s_len},
                      {32'h1000, 6'd0, 26'd64});
            tick();
        end
        wait_sweep(200, n);
        check("stall_status", 64'(t_st[0]), 64'd2);

        // dma_err during WAIT of slot 1 (slots 1 and 3 READY)
        reset_resp();
        clear_table();
        t_st[1] = 2'd1; t_ssz[1] = 26'd64; t_dsz[1] = 26'd64;
        t_st[3] = 2'd1; t_ssz[3] = 26'd32; t_dsz[3] = 26'd32;
        rq[0].push_back('{r: 0, d: 30});
        rq[1].push_back('{r: 0, d: 30});
        start_sweep();
        wait_valid(20);
        tick(); tick();
        dma_err = 1'b1;
        wait_sweep(100, n);
        check("err_slot1_status", 64'(t_st[1]), 64'd3);
        check("err_slot1_profile", 64'(t_prof[1]), 64'd3);
        check("err_flag_set", 64'(err_flag), 64'd1);
        check("err_slot3_untouched", 64'(t_st[3]), 64'd1);
        check("err_writes", 64'(n_wr), 64'd1);
        reset_resp();
        rq[0].push_back('{r: 0, d: 1});
        rq[1].push_back('{r: 0, d: 1});
        start_sweep();
        check("err_flag_cleared_by_start", 64'(err_flag), 64'd0);
        wait_sweep(100, n);
        check("err_rerun_slot3", 64'(t_st[3]), 64'd2);

        // stop during WAIT of slot 0 (slots 0 and 1 READY)
        reset_resp();
        clear_table();
        t_st[0] = 2'd1; t_ssz[0] = 26'd16; t_dsz[0] = 26'd16;
        t_st[1] = 2'd1; t_ssz[1] = 26'd16; t_dsz[1] = 26'd16;
        rq[0].push_back('{r: 0, d: 6});
        rq[1].push_back('{r: 0, d: 6});
        start_sweep();
        wait_valid(20);
        tick(); tick();
        stop = 1'b1;
        wait_sweep(100, n);
        stop = 1'b0;
        check("stop_slot0_done", 64'(t_st[0]), 64'd2);
        check("stop_slot1_ready", 64'(t_st[1]), 64'd1);
        check("stop_writes", 64'(n_wr), 64'd1);

        // Reset while in ISSUE: outputs clear, no writeback afterwards
        reset_resp();
        clear_table();
        t_st[0] = 2'd1; t_ssz[0] = 26'd16; t_dsz[0] = 26'd16;
        rq[0].push_back('{r: 50, d: 0});
        rq[1].push_back('{r: 50, d: 0});
        start_sweep();
        wait_valid(20);
        tick();
        reset = 1'b1;
        tick();
        check("reset_in_issue_outputs_zero", 64'(any_out), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("reset_in_issue_no_write", 64'(n_wr), 64'd0);
        check("reset_in_issue_slot_ready", 64'(t_st[0]), 64'd1);

        // Randomized sweeps against the outcome/timing model
        for (int sw = 0; sw < 15; sw++) begin
            int exp_len, p;
            logic [STW-1:0] exp_st[NS];
            logic [PW-1:0]  exp_pr[NS];
            logic [AW-1:0]  ea[2][$];
            logic [SW-1:0]  el[2][$];
            resp_t rm, rs;
            reset_resp();
            ea[0].delete(); ea[1].delete(); el[0].delete(); el[1].delete();
            exp_len = 1;
            for (int i = 0; i < NS; i++) begin
                int pick = int'($urandom_range(0, 9));
                t_src[i] = $urandom; t_des[i] = $urandom;
                t_ssz[i] = ($urandom_range(0, 3) == 0) ? 26'd0 : SW'($urandom_range(1, 4096));
                t_dsz[i] = ($urandom_range(0, 3) == 0) ? 26'd0 : SW'($urandom_range(1, 4096));
                t_st[i] = (pick < 6) ? 2'd1 : (pick == 6) ? 2'd0 : (pick == 7) ? 2'd2 : 2'd3;
                t_prof[i] = $urandom;
                if (t_st[i] == 2'd1) begin
                    rm.r = int'($urandom_range(0, 3)); rm.d = int'($urandom_range(0, 6));
                    rs.r = int'($urandom_range(0, 3)); rs.d = int'($urandom_range(0, 6));
                    p = model_profile(t_ssz[i], t_dsz[i], rm, rs);
                    exp_st[i] = 2'd2;
                    exp_pr[i] = PW'(p);
                    exp_len += p + 3;
                    if (t_ssz[i] != 0) begin
                        rq[0].push_back(rm); ea[0].push_back(t_src[i]); el[0].push_back(t_ssz[i]);
                    end
                    if (t_dsz[i] != 0) begin
                        rq[1].push_back(rs); ea[1].push_back(t_des[i]); el[1].push_back(t_dsz[i]);
                    end
                end else begin
                    exp_st[i] = t_st[i];
                    exp_pr[i] = t_prof[i];
                    exp_len += 2;
                end
            end
            start_sweep();
            wait_sweep(1000, n);
            check($sformatf("rnd%0d_sweep_cycles", sw), 64'(n), 64'(exp_len));
            for (int i = 0; i < NS; i++) begin
                check($sformatf("rnd%0d_slot%0d_status", sw, i), 64'(t_st[i]), 64'(exp_st[i]));
                check($sformatf("rnd%0d_slot%0d_profile", sw, i), 64'(t_prof[i]), 64'(exp_pr[i]));
            end
            for (int c = 0; c < 2; c++) begin
                check($sformatf("rnd%0d_ch%0d_cmd_count", sw, c), 64'(hs_a[c].size()),
                      64'(ea[c].size()));
                for (int j = 0; j < ea[c].size() && j < hs_a[c].size(); j++)
                    check($sformatf("rnd%0d_ch%0d_cmd%0d", sw, c, j),
                          {hs_a[c][j], 6'd0, hs_l[c][j]}, {ea[c][j], 6'd0, el[c][j]});
            end
            check($sformatf("rnd%0d_err_flag", sw), 64'(err_flag), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/slot_sequencer.md
Name: slot_sequencer

Overview:
- Walks the slot table in index order and launches one MM2S/S2MM transfer pair per READY slot.
- Waits for both transfers to complete, then writes back the slot status and a cycle-count profile.
- Sits between the slot table's read/write ports and the DMA command interface; software fills slots, then pulses start.

Parameters:
INDEX_WIDTH, 3, slot index width; the table holds 2^INDEX_WIDTH slots
ADDR_WIDTH, 32, source and destination address width
SIZE_WIDTH, 26, transfer length width in bytes
STATUS_WIDTH, 2, slot status width; encoding 0 EMPTY, 1 READY, 2 DONE, 3 ERROR
PROFILE_WIDTH, 32, profile counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse that begins a sweep from slot 0
stop  in  1  level; finish the current slot, then go idle
busy  out  1  high whenever the FSM is not IDLE
sweep_done  out  1  one-cycle pulse on return to IDLE
err_flag  out  1  sticky; set on dma_err, cleared by the next accepted start
cur_slot  out  INDEX_WIDTH  index currently being processed
tbl_out_index  out  INDEX_WIDTH  table read index; table read is combinational
tbl_src_addr  in  ADDR_WIDTH  slot source address
tbl_src_size  in  SIZE_WIDTH  slot source length
tbl_des_addr  in  ADDR_WIDTH  slot destination address
tbl_des_size  in  SIZE_WIDTH  slot destination length
tbl_status  in  STATUS_WIDTH  slot status
tbl_inp_index  out  INDEX_WIDTH  table write index
tbl_inp_status  out  STATUS_WIDTH  status write data
tbl_inp_profile  out  PROFILE_WIDTH  profile write data
tbl_set_status  out  1  status write strobe
tbl_set_profile  out  1  profile write strobe
mm2s_valid  out  1  load command valid
mm2s_ready  in  1  load command accept
mm2s_addr  out  ADDR_WIDTH  load address
mm2s_len  out  SIZE_WIDTH  load length
mm2s_done  in  1  load completion pulse
s2mm_valid  out  1  store command valid
s2mm_ready  in  1  store command accept
s2mm_addr  out  ADDR_WIDTH  store address
s2mm_len  out  SIZE_WIDTH  store length
s2mm_done  in  1  store completion pulse
dma_err  in  1  error pulse from either channel

Behaviour:
- Reset: FSM=IDLE. All outputs 0, including every valid, strobe, flag, cur_slot and tbl_out_index. Reset mid-transfer abandons the in-flight DMA; no writeback occurs.
- tbl_out_index = cur_slot at all times; tbl_inp_index = cur_slot.
- States: IDLE, FETCH, ISSUE, WAIT, WRBACK, NEXT.
- IDLE: start → cur_slot=0, clear err_flag, go FETCH. start is ignored while busy.
- FETCH (1 cycle): if tbl_status≠READY → NEXT. Otherwise latch addresses and sizes, clear profile counter, go ISSUE.
- ISSUE: assert mm2s_valid when src_size≠0 and s2mm_valid when des_size≠0.
  - Each valid drops the cycle after its own valid&ready handshake; the channels are independent.
  - A zero-size channel is marked accepted and done immediately.
  - Go WAIT once both channels are accepted.
- Completion tracking: per-channel sticky done flags set on a *_done pulse in ISSUE or WAIT. A done pulse arriving in the same cycle as the handshake counts.
- WAIT: leave when both done flags are set → WRBACK.
- dma_err in ISSUE or WAIT: drop both valids, set err_flag, go WRBACK with ERROR.
- Profile counter: increments every cycle in ISSUE and WAIT, saturates at all-ones.
- WRBACK (1 cycle): tbl_set_status=tbl_set_profile=1, tbl_inp_status = DONE (2) or ERROR (3), tbl_inp_profile = counter value.
- NEXT (1 cycle): go IDLE and pulse sweep_done if any of these hold:
  - cur_slot is the last index;
  - stop is high;
  - err_flag is set.
  Otherwise cur_slot+1 → FETCH.
- stop has no effect in other states; the current slot always completes.
- Sweep ordering is strictly ascending; there is no wrap-around to slot 0 within a sweep.

Test Plan:
- Slot 0 READY (src 0x1000/64, dst 0x2000/64), others EMPTY; ready=1, done pulses 5 cycles after accept → slot 0 status=2, profile=6, both valids seen once, sweep_done after slot 7, busy low afterwards.
- All 8 slots EMPTY, start → no valid asserted, sweep_done exactly 17 cycles after start (8×FETCH+NEXT plus the start cycle).
- Slot 2 READY with src_size=0, dst 0x3000/16 → only s2mm_valid asserted; writeback status=2.
- mm2s_ready held low 4 cycles while s2mm_ready=1 → s2mm_valid drops after 1 cycle, mm2s_valid held with stable addr/len until accepted.
- dma_err pulse in WAIT on slot 1 of READY slots 1 and 3 → slot 1 status=3, err_flag=1, slot 3 untouched, sweep ends; next start clears err_flag.
- stop asserted during WAIT of slot 0 with slots 0 and 1 READY → slot 0 written DONE, then IDLE; slot 1 still READY. Reset during ISSUE → all outputs 0 next cycle, no table write.
